dekatron_step_seq: RTL and testbench

DEKATRON_STEP_SEQ -- requirements
Module: dekatron_step_seq

---
 rtl/dekatron_step_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_dekatron_step_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_step_seq.sv
// dekatron_step_seq
//   Turns INC/DEC/LOAD/CLEAR commands into timed step pulses for a 3-digit
//   dekatron counter (range 000..255). It also keeps a BCD mirror of the
//   counter value.
//
// Parameters
//   STEP_HIGH  Step high time in Clk cycles (1..15)
//   STEP_LOW   Step low time in Clk cycles (1..15)
//
// Ports
//   Clk        single clock, rising edge
//   Rst        asynchronous active-high reset
//   CmdValid   command offered
//   CmdReady   block can accept a command
//   CmdOp      00 INC by N, 01 DEC by N, 10 LOAD value, 11 CLEAR
//   CmdArg     INC/DEC: [7:0] binary N; LOAD: BCD value h[9:8] t[7:4] o[3:0]
//   Step       step pulse to the counter
//   Reverse    count direction to the counter (1 = down)
//   Set        load strobe to the counter
//   In         BCD load value to the counter
//   Count      BCD mirror of the counter value
//   Busy       command in progress
//   Done       one-cycle pulse, command complete
//   Err        one-cycle pulse, LOAD rejected
module dekatron_step_seq #(
  parameter int STEP_HIGH = 2,
  parameter int STEP_LOW  = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [1:0] CmdOp,
  input  logic [9:0] CmdArg,
  output logic       Step,
  output logic       Reverse,
  output logic       Set,
  output logic [9:0] In,
  output logic [9:0] Count,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_DEC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [3:0] HIGH_LAST = 4'(STEP_HIGH - 1);
  localparam logic [3:0] LOW_LAST  = 4'(STEP_LOW - 1);

  state_t      state_q, state_d;
  logic [7:0]  pulses_q, pulses_d;
  logic [3:0]  timer_q, timer_d;
  logic        reverse_q, reverse_d;
  logic        set_q, set_d;
  logic [9:0]  in_q, in_d;
  logic [9:0]  count_q, count_d;
  logic        reject_q, reject_d;
  logic        ready_q, ready_d;
  logic        active;

  // BCD +1 with digit carries; 255 wraps to 000 like the counter's limit reload.
  function automatic logic [9:0] bcd_inc(input logic [9:0] v);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = v[9:8];
    t = v[7:4];
    o = v[3:0];
    if (v == 10'h255) begin
      h = 2'd0;
      t = 4'd0;
      o = 4'd0;
    end else if (o == 4'd9) begin
      o = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 2'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {h, t, o};
  endfunction

  // BCD -1 with digit borrows; 000 wraps to 255.
  function automatic logic [9:0] bcd_dec(input logic [9:0] v);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = v[9:8];
    t = v[7:4];
    o = v[3:0];
    if (v == 10'h000) begin
      h = 2'd2;
      t = 4'd5;
      o = 4'd5;
    end else if (o == 4'd0) begin
      o = 4'd9;
      if (t == 4'd0) begin
        t = 4'd9;
        h = h - 2'd1;
      end else begin
        t = t - 4'd1;
      end
    end else begin
      o = o - 4'd1;
    end
    return {h, t, o};
  endfunction

  // A LOAD value is usable only if every digit is decimal and it is <= 255.
  function automatic logic load_ok(input logic [9:0] v);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = v[9:8];
    t = v[7:4];
    o = v[3:0];
    return (o <= 4'd9) && (t <= 4'd9) &&
           ((h < 2'd2) ||
            ((h == 2'd2) && ((t < 4'd5) || ((t == 4'd5) && (o <= 4'd5)))));
  endfunction

  // State and datapath registers; reset matches the counter's own reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      pulses_q  <= 8'd0;
      timer_q   <= 4'd0;
      reverse_q <= 1'b0;
      set_q     <= 1'b0;
      in_q      <= 10'd0;
      count_q   <= 10'd0;
      reject_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulses_q  <= pulses_d;
      timer_q   <= timer_d;
      reverse_q <= reverse_d;
      set_q     <= set_d;
      in_q      <= in_d;
      count_q   <= count_d;
      reject_q  <= reject_d;
      ready_q   <= ready_d;
    end
  end

  // A rejected LOAD goes straight to DONE with reject_q set, so its Err
  // cycle reuses DONE but raises Err instead of Done.
  always_comb begin
    state_d   = state_q;
    pulses_d  = pulses_q;
    timer_d   = timer_q;
    reverse_d = reverse_q;
    set_d     = set_q;
    in_d      = in_q;
    count_d   = count_q;
    reject_d  = reject_q;
    ready_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (CmdValid && CmdReady) begin
          timer_d   = 4'd0;
          reject_d  = 1'b0;
          reverse_d = 1'b0;
          set_d     = 1'b0;
          in_d      = 10'd0;
          pulses_d  = 8'd1;
          state_d   = SETUP;
          case (CmdOp)
            OP_INC: begin
              pulses_d = CmdArg[7:0];
            end
            OP_DEC: begin
              reverse_d = 1'b1;
              pulses_d  = CmdArg[7:0];
            end
            OP_LOAD: begin
              if (load_ok(CmdArg)) begin
                set_d = 1'b1;
                in_d  = CmdArg;
              end else begin
                reject_d = 1'b1;
                pulses_d = 8'd0;
                state_d  = DONE;
              end
            end
            OP_CLEAR: begin
              set_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      SETUP: begin
        state_d = (pulses_q != 8'd0) ? HIGH : DONE;
      end
      HIGH: begin
        if (timer_q == HIGH_LAST) begin
          timer_d  = 4'd0;
          pulses_d = pulses_q - 8'd1;
          state_d  = LOW;
          if (set_q) begin
            count_d = in_q;
          end else if (reverse_q) begin
            count_d = bcd_dec(count_q);
          end else begin
            count_d = bcd_inc(count_q);
          end
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      LOW: begin
        if (timer_q == LOW_LAST) begin
          timer_d = 4'd0;
          state_d = (pulses_q != 8'd0) ? HIGH : DONE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter controls are only presented while a command is driving it.
  assign active   = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);
  assign CmdReady = (state_q == IDLE) && ready_q;
  assign Step     = (state_q == HIGH);
  assign Reverse  = active && reverse_q;
  assign Set      = active && set_q;
  assign In       = active ? in_q : 10'd0;
  assign Count    = count_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE) && !reject_q;
  assign Err      = (state_q == DONE) && reject_q;

endmodule

// File: tb/tb_dekatron_step_seq.sv
// Scoreboard bench for dekatron_step_seq: the driver pushes expected pulse,
// Done and Err events for every accepted command, and a negedge monitor pops
// and compares them as the DUT produces them.
module tb_dekatron_step_seq;

  localparam int H = 2;
  localparam int L = 2;
  localparam int EV_STEP = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic       Clk;
  logic       Rst;
  logic       CmdValid;
  logic       CmdReady;
  logic [1:0] CmdOp;
  logic [9:0] CmdArg;
  logic       Step;
  logic       Reverse;
  logic       Set;
  logic [9:0] In;
  logic [9:0] Count;
  logic       Busy;
  logic       Done;
  logic       Err;

  typedef struct {
    int         kind;
    logic [9:0] cnt;
    logic       rev;
    logic       set;
    logic [9:0] in_val;
    int         at_cyc;
  } ev_t;

  ev_t sb[$];
  int  check_count = 0;
  int  fail_count  = 0;
  int  cyc         = 0;
  int  acc_cnt     = 0;
  int  model       = 0;

  dekatron_step_seq #(.STEP_HIGH(H), .STEP_LOW(L)) dut (
    .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdArg(CmdArg), .Step(Step), .Reverse(Reverse),
    .Set(Set), .In(In), .Count(Count), .Busy(Busy), .Done(Done), .Err(Err)
  );

  // Free-running clock and cycle/accept counters.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (CmdValid && CmdReady) acc_cnt <= acc_cnt + 1;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] to_bcd(input int v);
    return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic ev_t mk_ev(input int kind, input int cnt, input logic rev,
                                input logic set, input logic [9:0] in_val, input int at_cyc);
    ev_t e;
    e.kind   = kind;
    e.cnt    = to_bcd(cnt);
    e.rev    = rev;
    e.set    = set;
    e.in_val = in_val;
    e.at_cyc = at_cyc;
    return e;
  endfunction

  // Offer a command, wait for acceptance, and push what the DUT should do.
  task automatic applyStimulus(input logic [1:0] op, input logic [9:0] arg, input bit hold);
    int guard;
    int n;
    int h;
    int t;
    int o;
    int acc;
    @(negedge Clk);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdArg   = arg;
    guard    = 0;
    while (!CmdReady && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (!CmdReady) begin
      checkOutput("accept_timeout", 32'(CmdReady), 32'd1);
      CmdValid = 1'b0;
      return;
    end
    acc = cyc;
    n = int'(arg[7:0]);
    h = int'(arg[9:8]);
    t = int'(arg[7:4]);
    o = int'(arg[3:0]);
    case (op)
      2'b00, 2'b01: begin
        for (int i = 0; i < n; i++) begin
          model = (op == 2'b00) ? (model + 1) % 256 : (model + 255) % 256;
          sb.push_back(mk_ev(EV_STEP, model, op == 2'b01, 1'b0, 10'd0, 0));
        end
        sb.push_back(mk_ev(EV_DONE, model, 1'b0, 1'b0, 10'd0, acc + 2 + n * (H + L)));
      end
      2'b10: begin
        if (o <= 9 && t <= 9 && (h * 100 + t * 10 + o) <= 255) begin
          model = h * 100 + t * 10 + o;
          sb.push_back(mk_ev(EV_STEP, model, 1'b0, 1'b1, arg, 0));
          sb.push_back(mk_ev(EV_DONE, model, 1'b0, 1'b0, 10'd0, acc + 2 + (H + L)));
        end else begin
          sb.push_back(mk_ev(EV_ERR, model, 1'b0, 1'b0, 10'd0, acc + 1));
        end
      end
      default: begin
        model = 0;
        sb.push_back(mk_ev(EV_STEP, 0, 1'b0, 1'b1, 10'd0, 0));
        sb.push_back(mk_ev(EV_DONE, 0, 1'b0, 1'b0, 10'd0, acc + 2 + (H + L)));
      end
    endcase
    if (!hold) begin
      @(negedge Clk);
      CmdValid = 1'b0;
      CmdOp    = 2'($urandom);
      CmdArg   = 10'($urandom);
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(negedge Clk);
    while ((sb.size() != 0 || Busy) && guard < 400) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    checkOutput("count_idle", 32'(Count), 32'(to_bcd(model)));
  endtask

  // Monitor: pops one event per Step fall, Done pulse or Err pulse.
  initial begin
    ev_t  e;
    logic step_prev;
    logic busy_prev;
    step_prev = 1'b0;
    busy_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        step_prev = 1'b0;
        busy_prev = 1'b0;
      end else begin
        if (Busy && !busy_prev && sb.size() != 0 && sb[0].kind == EV_STEP) begin
          checkOutput("setup_reverse", 32'(Reverse), 32'(sb[0].rev));
          checkOutput("setup_set", 32'(Set), 32'(sb[0].set));
        end
        if (Step && !step_prev)
          checkOutput("step_expected", 32'(sb.size() != 0 && sb[0].kind == EV_STEP), 32'd1);
        if (!Step && step_prev) begin
          checkOutput("step_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("step_kind", 32'(e.kind), 32'(EV_STEP));
            checkOutput("count", 32'(Count), 32'(e.cnt));
            checkOutput("reverse", 32'(Reverse), 32'(e.rev));
            checkOutput("set", 32'(Set), 32'(e.set));
            if (e.set) checkOutput("in", 32'(In), 32'(e.in_val));
          end
        end
        if (Done) begin
          checkOutput("done_entry", 32'(sb.size() != 0), 32'd1);
          checkOutput("set_in_done", 32'(Set), 32'd0);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("done_kind", 32'(e.kind), 32'(EV_DONE));
            checkOutput("done_latency", 32'(cyc), 32'(e.at_cyc));
          end
        end
        if (Err) begin
          checkOutput("err_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("err_kind", 32'(e.kind), 32'(EV_ERR));
            checkOutput("err_latency", 32'(cyc), 32'(e.at_cyc));
          end
        end
        step_prev = Step;
        busy_prev = Busy;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_step"}, 32'(Step), 32'd0);
    checkOutput({tag, "_reverse"}, 32'(Reverse), 32'd0);
    checkOutput({tag, "_set"}, 32'(Set), 32'd0);
    checkOutput({tag, "_in"}, 32'(In), 32'd0);
    checkOutput({tag, "_count"}, 32'(Count), 32'd0);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(Done), 32'd0);
    checkOutput({tag, "_err"}, 32'(Err), 32'd0);
    checkOutput({tag, "_ready"}, 32'(CmdReady), 32'd0);
  endtask

  // Main sequence.
  initial begin
    int   rises;
    int   guard;
    int   acc_before;
    logic step_p;
    Rst      = 1'b0;
    CmdValid = 1'b0;
    CmdOp    = 2'b00;
    CmdArg   = 10'd0;
    #2 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checkResetOutputs("reset");
    Rst = 1'b0;
    #1 checkOutput("ready_before_edge", 32'(CmdReady), 32'd0);
    @(negedge Clk);
    checkOutput("ready_after_edge", 32'(CmdReady), 32'd1);

    $display("[TB] INC 3 from reset");
    applyStimulus(2'b00, 10'd3, 1'b0);
    waitIdle();

    $display("[TB] LOAD 254, INC 3 wrap, DEC 2 wrap");
    applyStimulus(2'b10, 10'h254, 1'b0);
    waitIdle();
    applyStimulus(2'b00, 10'd3, 1'b0);
    waitIdle();
    applyStimulus(2'b01, 10'd2, 1'b0);
    waitIdle();

    $display("[TB] rejected and accepted LOADs");
    applyStimulus(2'b10, 10'h19A, 1'b0);
    waitIdle();
    applyStimulus(2'b10, 10'h299, 1'b0);
    waitIdle();
    applyStimulus(2'b10, 10'h256, 1'b0);
    waitIdle();
    applyStimulus(2'b10, 10'h199, 1'b0);
    waitIdle();
    applyStimulus(2'b11, 10'h3FF, 1'b0);
    waitIdle();

    $display("[TB] INC 0 and random INC/DEC");
    applyStimulus(2'b00, 10'd0, 1'b0);
    waitIdle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'($urandom_range(0, 1)), 10'($urandom_range(0, 6)), 1'b0);
      waitIdle();
    end

    $display("[TB] CmdValid held during Busy");
    acc_before = acc_cnt;
    applyStimulus(2'b00, 10'd1, 1'b1);
    repeat (6) @(negedge Clk);
    CmdValid = 1'b0;
    waitIdle();
    checkOutput("accepts_while_busy", 32'(acc_cnt - acc_before), 32'd1);

    $display("[TB] reset during second HIGH of INC 5");
    applyStimulus(2'b00, 10'd5, 1'b0);
    rises  = 0;
    guard  = 0;
    step_p = 1'b0;
    while (rises < 2 && guard < 100) begin
      @(posedge Clk);
      #1;
      if (Step && !step_p) rises++;
      step_p = Step;
      guard++;
    end
    checkOutput("second_high_seen", 32'(rises), 32'd2);
    checkOutput("step_high_before_reset", 32'(Step), 32'd1);
    #1 Rst = 1'b1;
    sb.delete();
    model = 0;
    #1 checkResetOutputs("mid_reset");
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("ready_after_mid_reset", 32'(CmdReady), 32'd1);
    repeat (30) @(negedge Clk);
    checkOutput("no_events_after_reset", 32'(sb.size()), 32'd0);
    applyStimulus(2'b00, 10'd2, 1'b0);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
